mem_access_unit: RTL and testbench

- Sits between the EX/MEM pipeline register and the byte-addressed, big-endian 32-bit data memory.
- Converts MIPS load/store requests into word-aligned memory accesses:
  - lb/lbu/lh/lhu/lw: extracts and sign- or zero-extends the addressed bytes.
  - sb/sh: performed as a two-cycle read-modify-write, stalling the pipeline for one cycle.
  - sw: single-cycle write.
- Detects misaligned and out-of-range addresses and raises an address exception.

---
 rtl/mem_access_unit_if.sv | 33 +++
 rtl/mem_access_unit.sv | 143 ++++++++++++++
 tb/tb_mem_access_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Bundles the pipeline request, data-memory and result signals of mem_access_unit.
//   slave  : the access unit (takes requests and mem_rdata, drives memory and results)
//   master : the surroundings (pipeline + data memory)
// Signals: req_read/req_write/req_size/req_unsigned/req_addr/req_wdata (request),
//          mem_addr/mem_wdata/mem_we/mem_re/mem_rdata (data memory),
//          load_data/stall/addr_exc/exc_addr (results to the pipeline).
interface mem_access_unit_if;
    logic        req_read;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic [31:0] load_data;
    logic        stall;
    logic        addr_exc;
    logic [31:0] exc_addr;

    modport slave (
        input  req_read, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output mem_addr, mem_wdata, mem_we, mem_re, load_data, stall, addr_exc, exc_addr
    );

    modport master (
        output req_read, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_re, load_data, stall, addr_exc, exc_addr
    );
endinterface

// File: rtl/mem_access_unit.sv
// MIPS load/store access unit between EX/MEM and a big-endian, word-wide data memory.
// Loads complete in the request cycle; sw writes in one cycle; sb/sh are done as a
// read-modify-write (read + merge, then write) with one stall cycle. Misaligned or
// out-of-range requests raise a one-cycle addr_exc and record the address in exc_addr.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : mem_access_unit_if.slave (request, data memory and result signals)
module mem_access_unit #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input logic               clk,
    input logic               rst_n,
    mem_access_unit_if.slave  bus
);

    typedef enum logic [0:0] {StIdle, StRmwWr} state_e;

    state_e      state_q, state_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rmw_addr_q, rmw_addr_d;
    logic [31:0] exc_addr_q, exc_addr_d;

    logic [1:0]  off;
    logic        illegal;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign off = bus.req_addr[1:0];

    always_comb begin
        illegal = 1'b0;
        unique case (bus.req_size)
            2'b00:   illegal = 1'b0;
            2'b01:   illegal = off[0];
            2'b10:   illegal = (off != 2'b00);
            default: illegal = 1'b1;
        endcase
        if (bus.req_addr > 32'(MEM_BYTES - 1)) begin
            illegal = 1'b1;
        end
    end

    // Lane extraction and merge, big-endian: offset 0 is the most significant byte.
    always_comb begin
        rd_byte = 8'h00;
        merged  = bus.mem_rdata;
        unique case (off)
            2'd0: begin rd_byte = bus.mem_rdata[31:24]; end
            2'd1: begin rd_byte = bus.mem_rdata[23:16]; end
            2'd2: begin rd_byte = bus.mem_rdata[15:8];  end
            default: begin rd_byte = bus.mem_rdata[7:0]; end
        endcase
        rd_half = off[1] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];

        if (bus.req_size == 2'b00) begin
            unique case (off)
                2'd0:    merged[31:24] = bus.req_wdata[7:0];
                2'd1:    merged[23:16] = bus.req_wdata[7:0];
                2'd2:    merged[15:8]  = bus.req_wdata[7:0];
                default: merged[7:0]   = bus.req_wdata[7:0];
            endcase
        end else if (off[1]) begin
            merged[15:0] = bus.req_wdata[15:0];
        end else begin
            merged[31:16] = bus.req_wdata[15:0];
        end

        unique case (bus.req_size)
            2'b00:   load_ext = bus.req_unsigned ? {24'h0, rd_byte}
                                                 : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   load_ext = bus.req_unsigned ? {16'h0, rd_half}
                                                 : {{16{rd_half[15]}}, rd_half};
            default: load_ext = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        merge_d       = merge_q;
        rmw_addr_d    = rmw_addr_q;
        exc_addr_d    = exc_addr_q;
        bus.mem_addr  = {bus.req_addr[31:2], 2'b00};
        bus.mem_wdata = bus.req_wdata;
        bus.mem_we    = 1'b0;
        bus.mem_re    = 1'b0;
        bus.load_data = 32'h0;
        bus.stall     = 1'b0;
        bus.addr_exc  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.req_read || bus.req_write) begin
                    if (illegal) begin
                        bus.addr_exc = 1'b1;
                        exc_addr_d   = bus.req_addr;
                    end else if (bus.req_write) begin
                        // Write wins over a simultaneous read.
                        if (bus.req_size == 2'b10) begin
                            bus.mem_we = 1'b1;
                        end else begin
                            bus.mem_re = 1'b1;
                            bus.stall  = 1'b1;
                            merge_d    = merged;
                            rmw_addr_d = bus.req_addr;
                            state_d    = StRmwWr;
                        end
                    end else begin
                        bus.mem_re    = 1'b1;
                        bus.load_data = load_ext;
                    end
                end
            end
            StRmwWr: begin
                bus.mem_addr  = {rmw_addr_q[31:2], 2'b00};
                bus.mem_wdata = merge_q;
                // A reset arriving in this cycle abandons the write.
                bus.mem_we    = rst_n;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.exc_addr = exc_addr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            merge_q    <= 32'h0;
            rmw_addr_q <= 32'h0;
            exc_addr_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            merge_q    <= merge_d;
            rmw_addr_q <= rmw_addr_d;
            exc_addr_q <= exc_addr_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases followed by random traffic,
// compared against a byte-array reference model of the memory and the access rules.
module tb_mem_access_unit;

    localparam int unsigned MemBytes = 1024;

    logic clk;
    logic rst_n;
    mem_access_unit_if mif ();

    mem_access_unit #(.MEM_BYTES(MemBytes)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory seen by the DUT: word array, combinational read, write on the edge.
    logic [31:0] mem_w [MemBytes/4];
    assign mif.mem_rdata = mem_w[mif.mem_addr[9:2]];
    always @(posedge clk) begin
        if (mif.mem_we) mem_w[mif.mem_addr[9:2]] <= mif.mem_wdata;
    end

    // Reference model: byte-addressed memory and last exception address.
    logic [7:0]  ref_b [MemBytes];
    logic [31:0] exp_exc;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic set_word(input int unsigned a, input logic [31:0] v);
        mem_w[a/4] = v;
        for (int i = 0; i < 4; i++) ref_b[(a & ~3) + i] = v[8*(3-i) +: 8];
    endtask

    function automatic int unsigned nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic is_illegal(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        if (a % nbytes(sz) != 0) return 1'b1;
        return a >= MemBytes;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] a);
        int unsigned n = nbytes(sz);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_b[a + i]);
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        int unsigned n = nbytes(sz);
        for (int i = 0; i < n; i++) ref_b[a + i] = d[8*(n-1-i) +: 8];
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d);
        mif.req_read     = rd;
        mif.req_write    = wr;
        mif.req_size     = sz;
        mif.req_unsigned = uns;
        mif.req_addr     = a;
        mif.req_wdata    = d;
    endtask

    task automatic do_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d);
        logic bad, ld, st_w, st_sub;
        @(negedge clk);
        drive(rd, wr, sz, uns, a, d);
        #1;
        bad    = (rd || wr) && is_illegal(sz, a);
        ld     = rd && !wr && !bad;
        st_w   = wr && !bad && sz == 2'd2;
        st_sub = wr && !bad && sz != 2'd2;
        check("addr_exc", {31'h0, mif.addr_exc}, {31'h0, bad});
        check("load_data", mif.load_data, ld ? ref_load(sz, uns, a) : 32'h0);
        check("mem_re", {31'h0, mif.mem_re}, {31'h0, ld || st_sub});
        check("mem_we", {31'h0, mif.mem_we}, {31'h0, st_w});
        check("stall", {31'h0, mif.stall}, {31'h0, st_sub});
        if (st_w) check("sw_wdata", mif.mem_wdata, d);
        @(posedge clk);
        if (bad) exp_exc = a;
        if (st_sub) begin
            @(negedge clk);
            #1;
            check("rmw_we", {31'h0, mif.mem_we}, 32'h1);
            check("rmw_stall", {31'h0, mif.stall}, 32'h0);
            check("rmw_re", {31'h0, mif.mem_re}, 32'h0);
            check("rmw_exc", {31'h0, mif.addr_exc}, 32'h0);
            check("rmw_addr", mif.mem_addr, a & ~32'h3);
            @(posedge clk);
        end
        if (wr && !bad) ref_store(sz, a, d);
        #1;
        check("exc_addr", mif.exc_addr, exp_exc);
    endtask

    initial begin
        logic [31:0] a, w;
        logic [1:0]  sz;
        int unsigned r;

        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < MemBytes / 4; i++) set_word(i * 4, $urandom);
        exp_exc = 32'h0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_stall", {31'h0, mif.stall}, 32'h0);
        check("rst_we", {31'h0, mif.mem_we}, 32'h0);
        check("rst_re", {31'h0, mif.mem_re}, 32'h0);
        check("rst_exc", {31'h0, mif.addr_exc}, 32'h0);
        check("rst_load", mif.load_data, 32'h0);
        check("rst_exc_addr", mif.exc_addr, 32'h0);

        // Extraction and extension.
        set_word(32'h10, 32'h8899AABB);
        do_op(1'b1, 1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
        check("lb_const", ref_load(2'd0, 1'b0, 32'h11), 32'hFFFFFF99);
        do_op(1'b1, 1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
        do_op(1'b1, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
        do_op(1'b1, 1'b0, 2'd1, 1'b1, 32'h10, 32'h0);
        do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

        // Sub-word stores, then back-to-back readback.
        set_word(32'h20, 32'h11223344);
        do_op(1'b0, 1'b1, 2'd0, 1'b0, 32'h22, 32'h000000EE);
        check("sb_word", mem_w[32'h20/4], 32'h1122EE44);
        do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        set_word(32'h20, 32'h11223344);
        do_op(1'b0, 1'b1, 2'd1, 1'b0, 32'h20, 32'h0000CAFE);
        check("sh_word", mem_w[32'h20/4], 32'hCAFE3344);
        do_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h24, 32'hDEADBEEF);
        check("sw_word", mem_w[32'h24/4], 32'hDEADBEEF);

        // Illegal accesses.
        do_op(1'b1, 1'b0, 2'd1, 1'b0, 32'h13, 32'h0);
        check("exc_lh", mif.exc_addr, 32'h13);
        do_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h402, 32'h12345678);
        check("exc_sw", mif.exc_addr, 32'h402);

        // Reset during the write phase of a sub-word store.
        set_word(32'h30, 32'hA1B2C3D4);
        @(negedge clk);
        drive(1'b0, 1'b1, 2'd0, 1'b0, 32'h30, 32'h000000AB);
        #1;
        check("rst_rmw_stall1", {31'h0, mif.stall}, 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_rmw_we", {31'h0, mif.mem_we}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        exp_exc = 32'h0;
        #1;
        check("rst_rmw_stall", {31'h0, mif.stall}, 32'h0);
        check("rst_rmw_we2", {31'h0, mif.mem_we}, 32'h0);
        check("rst_rmw_word", mem_w[32'h30/4], 32'hA1B2C3D4);
        do_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0);

        // Simultaneous read and write: write wins.
        do_op(1'b1, 1'b1, 2'd2, 1'b0, 32'h40, 32'h5A5A5A5A);
        check("rw_word", mem_w[32'h40/4], 32'h5A5A5A5A);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            r  = $urandom_range(0, 19);
            sz = 2'($urandom_range(0, 3));
            if (r == 0)      a = $urandom;
            else if (r == 1) a = $urandom_range(MemBytes, MemBytes + 64);
            else             a = $urandom_range(0, MemBytes - 1);
            if ($urandom_range(0, 9) < 8) begin
                if (sz == 2'd1) a = a & ~32'h1;
                if (sz == 2'd2) a = a & ~32'h3;
            end
            if ($urandom_range(0, 9) < 8 && sz == 2'd3) sz = 2'($urandom_range(0, 2));
            r = $urandom_range(0, 9);
            w = $urandom;
            do_op(r < 5 || r == 9, r >= 5, sz, 1'($urandom_range(0, 1)), a, w);
        end

        @(negedge clk);
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < MemBytes / 4; i++) begin
            check("final_mem", mem_w[i],
                  {ref_b[4*i], ref_b[4*i+1], ref_b[4*i+2], ref_b[4*i+3]});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
